// File: rtl/ssd_clk_pkg.sv
// Shared types and config clamps for the multi-channel clock generator.
// Pure declarations and functions: no state, no latency, no flow control.
package ssd_clk_pkg;

    typedef enum logic [1:0] {
        RESET   = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam int unsigned MIN_DIV = 2;

    function automatic logic [31:0] clamp_div(input logic [31:0] div);
        return (div < MIN_DIV) ? 32'(MIN_DIV) : div;
    endfunction

    function automatic logic [31:0] clamp_phase(input logic [31:0] div, input logic [31:0] phase);
        return (phase >= div) ? 32'd0 : phase;
    endfunction

endpackage

// File: rtl/ssd_clk_gen_ch.sv
// One divided-clock channel: outclk/tick registered one cycle after the counter.
// No backpressure; counter holds while not running and reloads its phase on load.
module ssd_clk_gen_ch #(
    parameter int CNT_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] div,
    input  logic [CNT_W-1:0] phase,
    output logic             outclk,
    output logic             tick
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             outclk_q, outclk_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d    = cnt_q;
        outclk_d = 1'b0;
        tick_d   = 1'b0;
        if (load) begin
            // (div - phase) mod div, with phase already clamped below div
            cnt_d = (phase == '0) ? '0 : div - phase;
        end else if (run) begin
            tick_d   = (cnt_q == '0);
            outclk_d = (cnt_q < (div >> 1));
            cnt_d    = (cnt_q == div - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            cnt_q    <= '0;
            outclk_q <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            outclk_q <= outclk_d;
            tick_q   <= tick_d;
        end
    end

    assign outclk = outclk_q;
    assign tick   = tick_q;

endmodule

// File: rtl/ssd_clk_gen.sv
// Multi-channel clock generator: FSM, lock timer and per-channel config registers.
// cfg_ready is high only when locked; an accepted config restarts every channel together.
module ssd_clk_gen
    import ssd_clk_pkg::*;
#(
    parameter int                       NUM_CLK     = 4,
    parameter int                       CNT_W       = 16,
    parameter int                       LOCK_CYCLES = 16,
    parameter logic [NUM_CLK*CNT_W-1:0] DIV_INIT    = {NUM_CLK{16'd10}},
    localparam int                      CH_W        = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [CNT_W-1:0]   cfg_phase,
    output logic [NUM_CLK-1:0] outclk,
    output logic [NUM_CLK-1:0] tick,
    output logic               locked
);

    localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
    logic             locked_q, locked_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic [CNT_W-1:0] div_q   [NUM_CLK];
    logic [CNT_W-1:0] phase_q [NUM_CLK];

    logic             lock_done;
    logic             hs;
    logic             ch_ok;
    logic             cfg_hit;
    logic [CNT_W-1:0] new_div;
    logic [CNT_W-1:0] new_phase;

    assign lock_done = (state_q == LOCKING) && (lock_cnt_q == LCW'(LOCK_CYCLES - 1));
    assign hs        = cfg_valid && cfg_ready_q && (state_q == LOCKED);
    assign ch_ok     = (int'(cfg_ch) < NUM_CLK);
    // Out-of-range channels complete the handshake but leave everything running.
    assign cfg_hit   = hs && ch_ok;
    assign new_div   = CNT_W'(clamp_div(32'(cfg_div)));
    assign new_phase = CNT_W'(clamp_phase(32'(new_div), 32'(cfg_phase)));

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET:   state_d = LOCKING;
            LOCKING: state_d = lock_done ? LOCKED : LOCKING;
            LOCKED:  state_d = cfg_hit ? LOCKING : LOCKED;
            default: state_d = RESET;
        endcase
    end

    always_comb begin
        locked_d    = (state_q == LOCKED);
        cfg_ready_d = (state_q == LOCKED) && !hs;
        lock_cnt_d  = '0;
        if (state_q == LOCKING && !lock_done) begin
            lock_cnt_d = lock_cnt_q + LCW'(1);
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b0;
            lock_cnt_q  <= '0;
        end else begin
            locked_q    <= locked_d;
            cfg_ready_q <= cfg_ready_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    always_ff @(posedge refclk) begin
        for (int k = 0; k < NUM_CLK; k++) begin
            if (rst) begin
                div_q[k]   <= CNT_W'(clamp_div(32'(DIV_INIT[k*CNT_W +: CNT_W])));
                phase_q[k] <= '0;
            end else if (cfg_hit && int'(cfg_ch) == k) begin
                div_q[k]   <= new_div;
                phase_q[k] <= new_phase;
            end
        end
    end

    for (genvar g = 0; g < NUM_CLK; g++) begin : g_ch
        ssd_clk_gen_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .refclk (refclk),
            .rst    (rst),
            .run    (state_q == LOCKED),
            .load   (lock_done),
            .div    (div_q[g]),
            .phase  (phase_q[g]),
            .outclk (outclk[g]),
            .tick   (tick[g])
        );
    end

    assign locked    = locked_q;
    assign cfg_ready = cfg_ready_q;

endmodule
